// File: rtl/branch_tracker.sv
// Fetch/execute-side tracker for the 2-bit branch predictor: issues prediction
// requests, buffers in-flight predictions, resolves them and keeps statistics.
module branch_tracker #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     br_issue,
  output logic                     issue_ready,
  output logic                     request,
  input  logic                     prediction,
  output logic                     pred_valid,
  output logic                     pred_taken,
  input  logic                     br_resolve,
  input  logic                     br_actual,
  output logic                     result,
  output logic                     taken,
  output logic                     mispredict,
  output logic                     resolve_err,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         mispred_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic             r_fifo [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_pending;
  logic             r_result;
  logic             r_taken;
  logic             r_mispredict;
  logic             r_resolve_err;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic [CW-1:0]    w_occupancy;
  logic             w_ready;
  logic             w_res_ok;
  logic             w_head;
  logic             w_flush;
  logic             w_pop;
  logic             w_push;

  // A pending request already owns a slot, so it counts toward occupancy.
  assign w_occupancy = r_count + CW'(r_pending);
  assign w_ready     = (w_occupancy < CW'(DEPTH));
  assign issue_ready = w_ready & ~rst;
  assign request     = br_issue & issue_ready;

  assign pred_valid  = r_pending;
  assign pred_taken  = r_pending & prediction;
  assign inflight    = w_occupancy;

  assign w_res_ok = br_resolve & (r_count != '0);
  assign w_head   = r_fifo[r_rd_ptr];
  assign w_flush  = w_res_ok & (w_head != br_actual);
  assign w_pop    = w_res_ok & ~w_flush;
  assign w_push   = r_pending & ~w_flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= prediction;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else if (w_flush) begin
      // Everything younger than the mispredicted branch is on the wrong path.
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_pending <= request;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result      <= 1'b0;
      r_taken       <= 1'b0;
      r_mispredict  <= 1'b0;
      r_resolve_err <= 1'b0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_result      <= w_res_ok;
      r_taken       <= w_res_ok & br_actual;
      r_mispredict  <= w_flush;
      r_resolve_err <= br_resolve & (r_count == '0);
      if (w_res_ok && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + 1'b1;
      end
      if (w_flush && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

  assign result      = r_result;
  assign taken       = r_taken;
  assign mispredict  = r_mispredict;
  assign resolve_err = r_resolve_err;
  assign branch_cnt  = r_branch_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule
